// File: rtl/multdiv_pkg.sv
// Shared types and helpers for the iterative multiply/divide unit.
package multdiv_pkg;

    // Controller states; encodings are fixed so traces stay readable across revisions.
    typedef enum logic [1:0] {
        StIdle = 2'b00,
        StMult = 2'b01,
        StDiv  = 2'b10,
        StDone = 2'b11
    } state_e;

    // Operation selected when a request is accepted.
    typedef enum logic {
        OpMul = 1'b0,
        OpDiv = 1'b1
    } op_e;

    // Most negative two's-complement value for a given width (widths up to 64).
    function automatic logic [63:0] min_value(int unsigned width);
        return 64'd1 << (width - 1);
    endfunction

endpackage

// File: rtl/multdiv_iter_counter.sv
// Iteration counter: cleared when an operation starts, saturates at Width-1.
module multdiv_iter_counter #(
    parameter int unsigned Width = 32,
    parameter int unsigned CntW  = $clog2(Width) + 1
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clr_i,
    input  logic en_i,
    output logic terminal_o
);

    logic [CntW-1:0] cnt_q;

    assign terminal_o = (cnt_q == CntW'(Width - 1));

    // Count active iterations; holding at the terminal value means it can never wrap.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else if (clr_i) begin
            cnt_q <= '0;
        end else if (en_i && !terminal_o) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

endmodule

// File: rtl/multdiv_seq.sv
// Iterative signed multiply (radix-2 Booth) / divide (restoring) unit with a fixed
// WIDTH+1 cycle latency, busy indication for stall logic and a squash (flush) input.
module multdiv_seq
    import multdiv_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    input  logic             ctrl_MULT,
    input  logic             ctrl_DIV,
    input  logic             flush,
    output logic [WIDTH-1:0] data_result,
    output logic             data_exception,
    output logic             data_resultRDY,
    output logic             busy
);

    localparam int unsigned      CNT_W  = $clog2(WIDTH) + 1;
    localparam logic [WIDTH-1:0] MinVal = WIDTH'(min_value(WIDTH));

    function automatic logic [WIDTH-1:0] mag(logic [WIDTH-1:0] v);
        return v[WIDTH-1] ? -v : v;
    endfunction

    state_e             state_q, state_d;
    op_e                op_sel;
    logic               accept, start, terminal;

    // Multiply datapath: {hi, multiplier, booth guard bit}.
    logic [2*WIDTH:0]   p_q, p_d;
    logic [WIDTH-1:0]   mcand_q;
    logic [WIDTH:0]     hi_ext, mcand_ext, booth_sum;
    logic               mul_exc;

    // Divide datapath on magnitudes; sign and special cases applied at the end.
    logic [WIDTH-1:0]   dvsr_q, rem_q, quo_q, rem_d, quo_d, div_res;
    logic [WIDTH:0]     rem_shift;
    logic               ge, neg_q, dz_q, ovf_q;

    logic [WIDTH-1:0]   result_q;
    logic               exc_q;

    assign accept = ((state_q == StIdle) || (state_q == StDone)) && !flush;
    assign start  = accept && (ctrl_MULT || ctrl_DIV);
    assign op_sel = ctrl_MULT ? OpMul : OpDiv;

    assign busy           = (state_q == StMult) || (state_q == StDiv);
    assign data_resultRDY = (state_q == StDone);
    assign data_result    = result_q;
    assign data_exception = exc_q;

    multdiv_iter_counter #(
        .Width(WIDTH),
        .CntW (CNT_W)
    ) u_counter (
        .clk_i     (clock),
        .rst_i     (reset),
        .clr_i     (start),
        .en_i      (busy),
        .terminal_o(terminal)
    );

    // Next-state logic; flush overrides everything, including a same-cycle request.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle, StDone: begin
                if (start) begin
                    state_d = (op_sel == OpMul) ? StMult : StDiv;
                end else begin
                    state_d = StIdle;
                end
            end
            StMult, StDiv: begin
                if (terminal) begin
                    state_d = StDone;
                end
            end
            default: state_d = StIdle;
        endcase
        if (flush) begin
            state_d = StIdle;
        end
    end

    // State register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // One Booth step; the add is one bit wider so a MIN multiplicand cannot overflow.
    always_comb begin
        hi_ext    = {p_q[2*WIDTH], p_q[2*WIDTH:WIDTH+1]};
        mcand_ext = {mcand_q[WIDTH-1], mcand_q};
        unique case (p_q[1:0])
            2'b01:   booth_sum = hi_ext + mcand_ext;
            2'b10:   booth_sum = hi_ext - mcand_ext;
            default: booth_sum = hi_ext;
        endcase
        p_d     = {booth_sum, p_q[WIDTH:1]};
        mul_exc = !((&p_d[2*WIDTH:WIDTH]) || (~|p_d[2*WIDTH:WIDTH]));
    end

    // One restoring-divide step plus final sign/special-case fix-up.
    always_comb begin
        rem_shift = {rem_q, quo_q[WIDTH-1]};
        ge        = (rem_shift >= {1'b0, dvsr_q});
        rem_d     = ge ? (rem_shift[WIDTH-1:0] - dvsr_q) : rem_shift[WIDTH-1:0];
        quo_d     = {quo_q[WIDTH-2:0], ge};
        if (dz_q) begin
            div_res = '0;
        end else if (ovf_q) begin
            div_res = MinVal;
        end else begin
            div_res = neg_q ? -quo_d : quo_d;
        end
    end

    // Operand latch on accept (both datapaths loaded; state picks which one runs),
    // then one iteration per cycle unless squashed.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            p_q     <= '0;
            mcand_q <= '0;
            dvsr_q  <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            neg_q   <= 1'b0;
            dz_q    <= 1'b0;
            ovf_q   <= 1'b0;
        end else if (start) begin
            p_q     <= {{WIDTH{1'b0}}, data_operandB, 1'b0};
            mcand_q <= data_operandA;
            dvsr_q  <= mag(data_operandB);
            rem_q   <= '0;
            quo_q   <= mag(data_operandA);
            neg_q   <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
            dz_q    <= (data_operandB == '0);
            ovf_q   <= (data_operandA == MinVal) && (data_operandB == '1);
        end else if (!flush) begin
            if (state_q == StMult) begin
                p_q <= p_d;
            end
            if (state_q == StDiv) begin
                rem_q <= rem_d;
                quo_q <= quo_d;
            end
        end
    end

    // Result/exception capture on the edge entering DONE; held otherwise.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            result_q <= '0;
            exc_q    <= 1'b0;
        end else if (terminal && !flush) begin
            if (state_q == StMult) begin
                result_q <= p_d[WIDTH:1];
                exc_q    <= mul_exc;
            end else if (state_q == StDiv) begin
                result_q <= div_res;
                exc_q    <= dz_q | ovf_q;
            end
        end
    end

endmodule

// File: doc/multdiv_seq.md
Name: multdiv_seq

Overview:
- Parametrised iterative signed multiply/divide unit for the execute stage of the 5-stage pipeline.
- Replaces the fixed-width multdiv stub; adds a start/ready handshake, a busy signal for the hazard/stall logic, a flush input for branch/jump squash, and defined exception semantics.
- The pipeline holds DX/XM while busy=1 and writes data_result back when data_resultRDY pulses.

Parameters:
- WIDTH, 32, operand/result width in bits (≥4).
- CNT_W, $clog2(WIDTH)+1, iteration counter width (derived; not overridden).

Ports:
- clock  in  1  master clock, rising edge.
- reset  in  1  asynchronous, active-high; returns block to IDLE.
- data_operandA  in  WIDTH  multiplicand / dividend (two's complement).
- data_operandB  in  WIDTH  multiplier / divisor (two's complement).
- ctrl_MULT  in  1  start multiply; sampled only in IDLE or DONE.
- ctrl_DIV  in  1  start divide; sampled only in IDLE or DONE.
- flush  in  1  synchronous abort of the in-flight operation.
- data_result  out  WIDTH  low WIDTH bits of product, or quotient.
- data_exception  out  1  overflow or divide-by-zero for the last completed op.
- data_resultRDY  out  1  one-cycle completion pulse.
- busy  out  1  high while an operation is in flight (MULT or DIV state).

Behaviour:
- Reset (async, any state): state=IDLE; data_result=0, data_exception=0, data_resultRDY=0, busy=0; counter and internal registers cleared.
- States: IDLE, MULT, DIV, DONE.
- IDLE/DONE + ctrl_MULT: latch operands, go to MULT, counter=0.
- IDLE/DONE + ctrl_DIV (ctrl_MULT low): latch operands, go to DIV, counter=0.
- Both ctrl high: multiply wins; divide request dropped.
- ctrl_* while in MULT/DIV: ignored, no queuing.
- MULT/DIV: one iteration per cycle; after exactly WIDTH iterations go to DONE.
- DONE: data_resultRDY=1 for that single cycle. With no new ctrl, next state is IDLE; with a new ctrl, the next op is accepted that edge (back-to-back, no bubble).
- Latency: ctrl high in cycle 0 → RDY high in cycle WIDTH+1. Fixed for all operands, including exceptions.
- busy=1 in MULT and DIV; 0 in IDLE and DONE.
- Multiply: radix-2 Booth over a 2*WIDTH+1 product register. data_result = product[WIDTH-1:0]. data_exception=1 iff the full signed product does not fit in WIDTH bits (upper WIDTH+1 bits not all equal).
- Divide: restoring divide on operand magnitudes; sign fixed afterwards. Quotient truncates toward zero; remainder discarded.
- Divide by zero: data_result=0, data_exception=1.
- MIN/−1: data_result=MIN (2^(WIDTH-1) pattern), data_exception=1.
- data_result and data_exception are registered. Both update only on the edge entering DONE and hold until the next DONE.
- flush: synchronous, highest priority after reset. From any state: next state IDLE, no RDY pulse, result/exception registers unchanged. ctrl_* in the same cycle as flush is dropped.
- Counter never wraps: compare is terminal at WIDTH-1 and the counter is cleared on entry to MULT/DIV.

Decomposition:
- Package multdiv_pkg:
  - state enum (IDLE=2'b00, MULT=2'b01, DIV=2'b10, DONE=2'b11);
  - op-select constants;
  - MIN-value helper function of WIDTH.
- One natural sub-module: multdiv_iter_counter (CNT_W-bit counter with clear and terminal flag at WIDTH-1). Booth and restoring datapaths stay inline under the FSM.

Test Plan:
- WIDTH=32, ctrl_MULT with A=7, B=−6 (0xFFFFFFFA) → busy cycles 1–32, RDY only in cycle 33, result=0xFFFFFFD6 (−42), exception=0.
- ctrl_MULT with A=0x00010000, B=0x00010000 → result=0x00000000, exception=1. Then A=0x0000B505, B=0x0000B505 → exception=1 (product exceeds 2^31−1).
- ctrl_DIV with A=−43, B=5 → result=0xFFFFFFF8 (−8), exception=0. Then A=100, B=0 → result=0, exception=1, still at cycle 33.
- ctrl_DIV with A=0x80000000, B=0xFFFFFFFF → result=0x80000000, exception=1. Both ctrl high with A=3, B=4 → result=12 (mult taken).
- Start mult, flush in cycle 10 → IDLE in cycle 11, no RDY, previous result held. New ctrl_DIV in the DONE cycle of an op → accepted, RDY again exactly 33 cycles later. ctrl pulses while busy → ignored.
- Async reset asserted mid-divide (cycle 15, between edges) → all outputs 0 immediately, IDLE after release. Repeat the −42 multiply at WIDTH=8 (A=7, B=0xFA) → result 0xD6 in cycle 9.
